// File: rtl/sap1_pio_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sap1_pio_pkg
// Description : Shared types and constants for the SAP1 PIO bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sap1_pio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } pio_arb_state_e;

    localparam logic        PIO_RW_READ  = 1'b1;
    localparam logic        PIO_RW_WRITE = 1'b0;
    localparam logic [31:0] PIO_ERR_DATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; search starts at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW:0]    w_sum;
    logic           w_found;

    // Rotating a doubled copy puts requester (ptr+k) mod N at bit k.
    assign w_dbl = {req, req};
    assign w_rot = N'(w_dbl >> ptr);

    always_comb begin
        gnt_idx = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, ptr} + (IW+1)'(k);
                if (w_sum >= (IW+1)'(N)) begin
                    w_sum = w_sum - (IW+1)'(N);
                end
                gnt_idx = w_sum[IW-1:0];
            end
        end
        gnt = w_found ? (N'(1) << gnt_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/pio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pio_arbiter
// Description : Round-robin sharing of the SAP1 PIO command bus with read
//               hold, read timeout and response routing to the issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_arbiter
    import sap1_pio_pkg::*;
#(
    parameter int                NUM_REQ    = 2,
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 32,
    parameter int                RD_TIMEOUT = 16,
    parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(PIO_ERR_DATA)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_w,
    input  logic [NUM_REQ-1:0]        req_rw,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic [NUM_REQ-1:0]        rsp_rd_vld,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_data_r,
    output logic [ADDR_W-1:0]         pio_addr,
    output logic [DATA_W-1:0]         pio_data_w,
    output logic                      pio_rw,
    output logic                      pio_cmd_vld,
    input  logic                      pio_rd_vld,
    input  logic [DATA_W-1:0]         pio_data_r
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(RD_TIMEOUT);

    pio_arb_state_e    r_state;
    pio_arb_state_e    w_state_nxt;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     w_gnt_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ADDR_W-1:0] r_pio_addr;
    logic [DATA_W-1:0] r_pio_data_w;
    logic              r_pio_rw;
    logic [CW-1:0]     r_cnt;
    logic [NUM_REQ-1:0] r_rsp_vld;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_data;
    logic              w_accept;
    logic              w_rd_done;
    logic              w_timeout;
    logic [IW-1:0]     w_ptr_nxt;

    rr_arbiter #(
        .N       (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_vld),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_ptr_nxt = (w_gnt_idx == IW'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        req_rdy     = '0;
        pio_cmd_vld = 1'b0;
        w_accept    = 1'b0;
        w_rd_done   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                // A grant during reset would be silently lost, so none is offered.
                if ((|req_vld) && !reset) begin
                    req_rdy     = w_gnt;
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                pio_cmd_vld = 1'b1;
                w_state_nxt = (r_pio_rw == PIO_RW_READ) ? WAIT_RD : IDLE;
            end
            WAIT_RD: begin
                if (pio_rd_vld) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == CW'(RD_TIMEOUT-1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_pio_addr   <= '0;
            r_pio_data_w <= '0;
            r_pio_rw     <= PIO_RW_WRITE;
            r_cnt        <= '0;
            r_rsp_vld    <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rsp_vld <= '0;
            r_rsp_err <= 1'b0;
            if (w_accept) begin
                r_pio_addr   <= req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
                r_pio_data_w <= req_data_w[int'(w_gnt_idx)*DATA_W +: DATA_W];
                r_pio_rw     <= req_rw[w_gnt_idx];
                r_owner      <= w_gnt_idx;
                r_ptr        <= w_ptr_nxt;
            end
            if (r_state == ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == WAIT_RD) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Real data takes priority over a timeout landing in the same cycle.
            if (w_rd_done) begin
                r_rsp_vld  <= NUM_REQ'(1) << r_owner;
                r_rsp_data <= pio_data_r;
            end else if (w_timeout) begin
                r_rsp_vld  <= NUM_REQ'(1) << r_owner;
                r_rsp_err  <= 1'b1;
                r_rsp_data <= ERR_DATA;
            end
        end
    end

    assign rsp_rd_vld = r_rsp_vld;
    assign rsp_err    = r_rsp_err;
    assign rsp_data_r = r_rsp_data;
    assign pio_addr   = r_pio_addr;
    assign pio_data_w = r_pio_data_w;
    assign pio_rw     = r_pio_rw;

endmodule
`default_nettype wire

// File: tb/tb_pio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_arbiter
// Description : Self-checking bench for pio_arbiter against a cycle-level
//               behavioural model of the arbitration and response rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int RD_TIMEOUT = 16;
    localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data_w;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ-1:0]        req_rdy;
    logic [NUM_REQ-1:0]        rsp_rd_vld;
    logic                      rsp_err;
    logic [DATA_W-1:0]         rsp_data_r;
    logic [ADDR_W-1:0]         pio_addr;
    logic [DATA_W-1:0]         pio_data_w;
    logic                      pio_rw;
    logic                      pio_cmd_vld;
    logic                      pio_rd_vld;
    logic [DATA_W-1:0]         pio_data_r;

    always #5 clk = ~clk;

    pio_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_TIMEOUT (RD_TIMEOUT),
        .ERR_DATA   (ERR_DATA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_vld    (req_vld),
        .req_addr   (req_addr),
        .req_data_w (req_data_w),
        .req_rw     (req_rw),
        .req_rdy    (req_rdy),
        .rsp_rd_vld (rsp_rd_vld),
        .rsp_err    (rsp_err),
        .rsp_data_r (rsp_data_r),
        .pio_addr   (pio_addr),
        .pio_data_w (pio_data_w),
        .pio_rw     (pio_rw),
        .pio_cmd_vld(pio_cmd_vld),
        .pio_rd_vld (pio_rd_vld),
        .pio_data_r (pio_data_r)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: m_free = bus may be granted; m_wait_age = cycles since a read strobe (0 = none)
    bit                m_free;
    bit                m_cmd_due;
    int                m_ptr;
    int                m_owner;
    int                m_wait_age;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_rw;
    bit                m_rsp;
    int                m_rsp_owner;
    bit                m_rsp_err;
    logic [DATA_W-1:0] m_rsp_data;

    int   cyc = 0;
    int   last_cmd_cyc;
    int   last_rsp_cyc;
    logic last_rsp_err;
    logic [DATA_W-1:0] last_rsp_data;
    int   last_gnt;
    int   dut_grants[$];
    int   cmd_cycles[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_free      = 1'b1;
        m_cmd_due   = 1'b0;
        m_ptr       = 0;
        m_owner     = 0;
        m_wait_age  = 0;
        m_addr      = '0;
        m_wdata     = '0;
        m_rw        = 1'b0;
        m_rsp       = 1'b0;
        m_rsp_owner = 0;
        m_rsp_err   = 1'b0;
        m_rsp_data  = '0;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_vld[i] = 1'b1;
        req_rw[i]  = rw;
        req_addr[i*ADDR_W +: ADDR_W]   = a;
        req_data_w[i*DATA_W +: DATA_W] = d;
    endtask

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        logic [NUM_REQ-1:0] e_rdy;
        logic [NUM_REQ-1:0] e_rsp;
        int g;
        @(negedge clk);
        e_rdy = '0;
        g     = -1;
        if (m_free && !reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (m_ptr + k) % NUM_REQ;
                if (g < 0 && req_vld[i]) g = i;
            end
        end
        if (g >= 0) e_rdy[g] = 1'b1;
        e_rsp = '0;
        if (m_rsp) e_rsp[m_rsp_owner] = 1'b1;

        chk("req_rdy",     req_rdy,     e_rdy);
        chk("pio_cmd_vld", pio_cmd_vld, m_cmd_due);
        chk("pio_addr",    pio_addr,    m_addr);
        chk("pio_data_w",  pio_data_w,  m_wdata);
        chk("pio_rw",      pio_rw,      m_rw);
        chk("rsp_rd_vld",  rsp_rd_vld,  e_rsp);
        chk("rsp_err",     rsp_err,     m_rsp ? m_rsp_err : 1'b0);
        chk("rsp_data_r",  rsp_data_r,  m_rsp_data);

        if (pio_cmd_vld) begin
            last_cmd_cyc = cyc;
            cmd_cycles.push_back(cyc);
        end
        if (|rsp_rd_vld) begin
            last_rsp_cyc  = cyc;
            last_rsp_err  = rsp_err;
            last_rsp_data = rsp_data_r;
        end
        for (int k = 0; k < NUM_REQ; k++) if (req_rdy[k]) dut_grants.push_back(k);

        last_gnt = g;
        m_rsp    = 1'b0;
        if (reset) begin
            model_reset();
            last_gnt = -1;
        end else begin
            if (m_wait_age > 0) begin
                if (pio_rd_vld) begin
                    m_rsp = 1'b1; m_rsp_owner = m_owner; m_rsp_err = 1'b0;
                    m_rsp_data = pio_data_r; m_wait_age = 0; m_free = 1'b1;
                end else if (m_wait_age == RD_TIMEOUT) begin
                    m_rsp = 1'b1; m_rsp_owner = m_owner; m_rsp_err = 1'b1;
                    m_rsp_data = ERR_DATA; m_wait_age = 0; m_free = 1'b1;
                end else begin
                    m_wait_age++;
                end
            end
            if (m_cmd_due) begin
                m_cmd_due = 1'b0;
                if (m_rw) m_wait_age = 1;
                else      m_free = 1'b1;
            end
            if (g >= 0) begin
                m_addr    = req_addr[g*ADDR_W +: ADDR_W];
                m_wdata   = req_data_w[g*DATA_W +: DATA_W];
                m_rw      = req_rw[g];
                m_owner   = g;
                m_ptr     = (g + 1) % NUM_REQ;
                m_cmd_due = 1'b1;
                m_free    = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset      = 1'b1;
        req_vld    = '0;
        req_rw     = '0;
        req_addr   = '0;
        req_data_w = '0;
        pio_rd_vld = 1'b0;
        pio_data_r = '0;
        last_cmd_cyc = -1;
        last_rsp_cyc = -1;
        last_rsp_err = 1'b0;
        last_rsp_data = '0;
        last_gnt   = -1;
        model_reset();
        @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;

        // Single write from requester 0
        set_req(0, 1'b0, 16'h0010, 32'h1234_5678);
        cycle();
        req_vld[0] = 1'b0;
        repeat (3) cycle();

        // Read from requester 1, data returned three cycles after the strobe
        set_req(1, 1'b1, 16'h0020, 32'h0);
        cycle();
        req_vld[1] = 1'b0;
        repeat (3) cycle();
        pio_rd_vld = 1'b1;
        pio_data_r = 32'hCAFE_0001;
        cycle();
        pio_rd_vld = 1'b0;
        cycle();
        chk("rd_latency", 64'(last_rsp_cyc - last_cmd_cyc), 64'd4);
        chk("rd_data", last_rsp_data, 32'hCAFE_0001);

        // Timeout on requester 1, then a stray late pio_rd_vld
        set_req(1, 1'b1, 16'h0030, 32'h0);
        cycle();
        req_vld[1] = 1'b0;
        repeat (18) cycle();
        chk("to_latency", 64'(last_rsp_cyc - last_cmd_cyc), 64'd17);
        chk("to_err", last_rsp_err, 1'b1);
        chk("to_data", last_rsp_data, ERR_DATA);
        pio_rd_vld = 1'b1;
        pio_data_r = 32'h5555_AAAA;
        cycle();
        pio_rd_vld = 1'b0;
        repeat (2) cycle();

        // Round-robin with both requesters writing continuously
        dut_grants.delete();
        cmd_cycles.delete();
        set_req(0, 1'b0, 16'h0100, 32'h0000_0100);
        set_req(1, 1'b0, 16'h0200, 32'h0000_0200);
        repeat (12) cycle();
        req_vld = '0;
        repeat (2) cycle();
        chk("rr_count", 64'(dut_grants.size()), 64'd6);
        for (int k = 0; k < 6 && k < dut_grants.size(); k++)
            chk("rr_order", 64'(dut_grants[k]), 64'(k % 2));
        for (int k = 1; k < cmd_cycles.size(); k++)
            chk("rr_spacing", 64'(cmd_cycles[k] - cmd_cycles[k-1]), 64'd2);

        // Data and timeout collide: data must win
        set_req(0, 1'b1, 16'h0040, 32'h0);
        cycle();
        req_vld[0] = 1'b0;
        cycle();
        repeat (15) cycle();
        pio_rd_vld = 1'b1;
        pio_data_r = 32'hA5A5_0F0F;
        cycle();
        pio_rd_vld = 1'b0;
        cycle();
        chk("col_latency", 64'(last_rsp_cyc - last_cmd_cyc), 64'd17);
        chk("col_err", last_rsp_err, 1'b0);
        chk("col_data", last_rsp_data, 32'hA5A5_0F0F);

        // Reset in the middle of a read
        set_req(1, 1'b1, 16'h0050, 32'h0);
        cycle();
        req_vld[1] = 1'b0;
        repeat (4) cycle();
        last_rsp_cyc = -1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        pio_rd_vld = 1'b1;
        pio_data_r = 32'h0BAD_0BAD;
        cycle();
        pio_rd_vld = 1'b0;
        dut_grants.delete();
        set_req(0, 1'b0, 16'h0060, 32'h6);
        set_req(1, 1'b0, 16'h0070, 32'h7);
        cycle();
        req_vld = '0;
        repeat (2) cycle();
        chk("rst_no_rsp", 64'(last_rsp_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_first_gnt", 64'(dut_grants.size() > 0 ? dut_grants[0] : -1), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_vld[i] || last_gnt == i) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, 1'($urandom_range(0, 1)), 16'($urandom), 32'($urandom));
                    else
                        req_vld[i] = 1'b0;
                end else if ($urandom_range(0, 19) == 0) begin
                    req_vld[i] = 1'b0;
                end
            end
            pio_rd_vld = ($urandom_range(0, 9) == 0);
            pio_data_r = 32'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pio_arbiter.md
Name: pio_arbiter

Overview:
- Shares the single SAP1 PIO command bus between NUM_REQ requesters, e.g. the host bridge and a debug/loader master.
- Arbitrates round-robin and issues one PIO command at a time.
- Holds the bus during a read until the read data returns or a timeout expires.
- Routes the read response back to the requester that issued it.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 16, PIO address width
DATA_W, 32, PIO data width
RD_TIMEOUT, 16, cycles to wait in WAIT_RD for pio_rd_vld before an error response (>=2)
ERR_DATA, 32'hDEAD_BEEF, data returned on a read timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_vld  in  NUM_REQ  per-requester command valid; held until accepted
req_addr  in  NUM_REQ*ADDR_W  packed per-requester address (requester i at [i*ADDR_W +: ADDR_W])
req_data_w  in  NUM_REQ*DATA_W  packed per-requester write data
req_rw  in  NUM_REQ  1=read, 0=write
req_rdy  out  NUM_REQ  one-hot accept; the command transfers when req_vld[i]&&req_rdy[i]
rsp_rd_vld  out  NUM_REQ  one-cycle read-response pulse to the owning requester
rsp_err  out  1  qualifies rsp_rd_vld; 1 = timeout
rsp_data_r  out  DATA_W  read data, valid with rsp_rd_vld
pio_addr  out  ADDR_W  PIO address
pio_data_w  out  DATA_W  PIO write data
pio_rw  out  1  1=read, 0=write
pio_cmd_vld  out  1  one-cycle command strobe
pio_rd_vld  in  1  PIO read-data valid
pio_data_r  in  DATA_W  PIO read data

Behaviour:
- Reset values:
  - FSM is in IDLE.
  - RR pointer = 0.
  - pio_cmd_vld, rsp_rd_vld, rsp_err, req_rdy = 0.
  - pio_addr, pio_data_w, rsp_data_r = 0; pio_rw = 0.
- Reset mid-operation aborts any pending read. No response is ever generated for the aborted command.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any req_vld is set, the RR arbiter picks a winner g, starting the search at ptr and wrapping modulo NUM_REQ.
  - req_rdy[g]=1 combinationally in this cycle only; all other req_rdy bits are 0.
  - At the clock edge: capture addr/data/rw of g into the pio_* registers, set owner=g, set ptr=(g+1) mod NUM_REQ, go to ISSUE.
  - If no req_vld is set, stay in IDLE and leave ptr unchanged.
- ISSUE:
  - pio_cmd_vld=1 for exactly this one cycle.
  - req_rdy is all 0.
  - Next state: WAIT_RD if rw=1 (clear the timeout counter), otherwise IDLE.
- WAIT_RD:
  - req_rdy is all 0 and pio_cmd_vld is 0; pio_* fields hold their values.
  - The counter increments each cycle.
  - If pio_rd_vld=1: on the next cycle rsp_rd_vld[owner]=1, rsp_data_r=pio_data_r (registered), rsp_err=0, and the FSM returns to IDLE.
  - Else if counter==RD_TIMEOUT-1: on the next cycle rsp_rd_vld[owner]=1, rsp_err=1, rsp_data_r=ERR_DATA, and the FSM returns to IDLE.
  - If pio_rd_vld and the timeout occur in the same cycle, pio_rd_vld wins: data is returned with rsp_err=0.
- Stray pio_rd_vld in IDLE or ISSUE is ignored; no response is generated.
- A late pio_rd_vld arriving after a timeout is likewise ignored.
- Latency:
  - Accept at cycle T gives pio_cmd_vld at T+1.
  - Earliest next accept is T+2 for a write, and the cycle after the response for a read.
  - pio_rd_vld at cycle R gives rsp_rd_vld at R+1.
- rsp_rd_vld is one-hot or zero and lasts exactly one cycle. rsp_err is 0 whenever rsp_rd_vld is 0.
- The response pulse coincides with the IDLE cycle, so a new grant may be issued in the same cycle as the response.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 other commands.
- A requester must keep its command stable while req_vld=1 and req_rdy=0. Deasserting req_vld before accept is permitted; that requester is then simply not granted.

Decomposition:
- Package sap1_pio_pkg holds:
  - the state enum pio_arb_state_e {IDLE, ISSUE, WAIT_RD}
  - the constants PIO_RW_READ=1'b1 and PIO_RW_WRITE=1'b0
  - PIO_ERR_DATA=32'hDEAD_BEEF
- Sub-module rr_arbiter (parameter N; ports: req[N], ptr, gnt one-hot[N], gnt_idx) is purely combinational and reusable.
- All state, capture and timeout logic stays in pio_arbiter.

Test Plan:
- Single write: after reset, req_vld[0]=1, rw=0, addr=16'h0010, data=32'h1234_5678. Required: req_rdy[0]=1 at T; pio_cmd_vld=1 with the same addr/data and rw=0 at T+1 only; no rsp_rd_vld.
- Read with data: req 1 reads addr 16'h0020; the bench drives pio_rd_vld with 32'hCAFE_0001 three cycles after pio_cmd_vld. Required: rsp_rd_vld[1] one cycle later, rsp_data_r=32'hCAFE_0001, rsp_err=0; req_rdy stays all-zero until then.
- Timeout: read with pio_rd_vld never asserted, RD_TIMEOUT=16. Required: rsp_rd_vld[owner]=1, rsp_err=1, rsp_data_r=32'hDEAD_BEEF exactly 17 cycles after pio_cmd_vld. A later stray pio_rd_vld produces no response.
- Round-robin: both requesters hold write req_vld for 6 commands. Required: grant order 0,1,0,1,0,1 with pio_cmd_vld every 2 cycles.
- Collision: pio_rd_vld asserted in the same cycle the counter hits RD_TIMEOUT-1. Required: rsp_err=0 and the real data is returned.
- Reset mid-read: assert reset while in WAIT_RD. Required: all outputs return to their reset values next cycle; no rsp_rd_vld appears even if pio_rd_vld arrives afterwards; the next grant goes to requester 0.
